misr_sig_bench: RTL and testbench

//  Parametrised multi-channel signature-compaction load for clock-mesh benchmark runs.
//  NUM_CH independent WIDTH-bit MISRs (multiple-input signature registers) compact their

---
 rtl/misr_sig_bench_if.sv | 22 ++
 rtl/misr_sig_bench.sv | 109 ++++++++++
 tb/tb_misr_sig_bench.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/misr_sig_bench_if.sv
// misr_sig_bench_if: control and data bundle for misr_sig_bench.
//   master drives clr/start/run_len/din and observes busy/done/sig/sig_xor.
//   slave is the MISR block side.
interface misr_sig_bench_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 8
);
   logic                      clr;
   logic                      start;
   logic [CNT_W-1:0]          run_len;
   logic [NUM_CH*WIDTH-1:0]   din;
   logic                      busy;
   logic                      done;
   logic [NUM_CH*WIDTH-1:0]   sig;
   logic [WIDTH-1:0]          sig_xor;

   modport master (output clr, start, run_len, din,
                   input  busy, done, sig, sig_xor);
   modport slave  (input  clr, start, run_len, din,
                   output busy, done, sig, sig_xor);
endinterface

// File: rtl/misr_sig_bench.sv
// misr_sig_bench: NUM_CH independent WIDTH-bit MISRs compacting their din slices
// for a programmed number of cycles under an IDLE/RUN/DONE controller.
// Ports:
//   blif_clk_net    rising-edge clock
//   blif_reset_net  async active-low reset
//   bus (slave)     clr, start, run_len, din in; busy, done, sig, sig_xor out
//                   channel c lives at [c*WIDTH +: WIDTH] of din and sig

// One MISR channel. zero has priority over upd so a restart or clear always
// begins compaction from an all-zero register.
module misr_sig_lane #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = 'h1D
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   input  logic             zero,
   input  logic             upd,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] m
);
   logic [WIDTH-1:0] m_nxt;

   // Shift left; the bit falling off the top folds back through the tap mask.
   assign m_nxt = {m[WIDTH-2:0], 1'b0} ^ (m[WIDTH-1] ? POLY : '0) ^ d;

   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net)  m <= '0;
      else if (zero)        m <= '0;
      else if (upd)         m <= m_nxt;
   end
endmodule

module misr_sig_bench #(
   parameter int               NUM_CH = 4,
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] POLY   = 'h1D,
   parameter int               CNT_W  = 8
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   misr_sig_bench_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                         state;
   logic [CNT_W-1:0]               cnt;
   logic                           zero;
   logic                           upd;
   logic [NUM_CH-1:0][WIDTH-1:0]   din_v;
   logic [NUM_CH-1:0][WIDTH-1:0]   sig_v;
   logic [WIDTH-1:0]               sig_x;

   // A start is only honoured outside RUN; clear zeroes regardless of state.
   assign zero = bus.clr | (bus.start & (state != RUN));
   assign upd  = (state == RUN);

   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (bus.clr) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  cnt   <= bus.run_len;
                  state <= (bus.run_len != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               cnt <= cnt - CNT_W'(1);
               // cnt==1 marks the final update; counter lands on 0 with DONE.
               if (cnt == CNT_W'(1)) state <= DONE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);

   assign din_v = bus.din;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      misr_sig_lane #(.WIDTH(WIDTH), .POLY(POLY)) u_lane (
         .blif_clk_net   (blif_clk_net),
         .blif_reset_net (blif_reset_net),
         .zero           (zero),
         .upd            (upd),
         .d              (din_v[c]),
         .m              (sig_v[c])
      );
   end

   always_comb begin
      sig_x = '0;
      for (int c = 0; c < NUM_CH; c++) sig_x = sig_x ^ sig_v[c];
   end

   assign bus.sig     = sig_v;
   assign bus.sig_xor = sig_x;
endmodule

// File: tb/tb_misr_sig_bench.sv
// tb_misr_sig_bench: directed checks of a 1-channel and a 4-channel instance
// sharing clock, reset and control; each has its own din.
module tb_misr_sig_bench;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  run_len = '0;
   logic [7:0]  din1 = '0;
   logic [31:0] din4 = '0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   misr_sig_bench_if #(.NUM_CH(1), .WIDTH(8), .CNT_W(8)) if1 ();
   misr_sig_bench_if #(.NUM_CH(4), .WIDTH(8), .CNT_W(8)) if4 ();

   assign if1.clr = clr;   assign if1.start = start;
   assign if1.run_len = run_len;   assign if1.din = din1;
   assign if4.clr = clr;   assign if4.start = start;
   assign if4.run_len = run_len;   assign if4.din = din4;

   misr_sig_bench #(.NUM_CH(1), .WIDTH(8), .POLY(8'h1D), .CNT_W(8)) u_dut1 (
      .blif_clk_net(clk), .blif_reset_net(rst_n), .bus(if1));
   misr_sig_bench #(.NUM_CH(4), .WIDTH(8), .POLY(8'h1D), .CNT_W(8)) u_dut4 (
      .blif_clk_net(clk), .blif_reset_net(rst_n), .bus(if4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_busy", if1.busy, 1'b0);
      chk("rst_done", if1.done, 1'b0);
      chk("rst_sig4", if4.sig, 32'h0);
      chk("rst_xor4", if4.sig_xor, 8'h00);
      #5 rst_n = 1'b1;
      tick();
      chk("idle_busy", if1.busy, 1'b0);

      // 1: run_len=3, din=01 constant -> 01,03,07
      start = 1'b1; run_len = 8'd3; din1 = 8'h01;
      tick();
      start = 1'b0;
      chk("t1_busy0", if1.busy, 1'b1);
      chk("t1_sig0", if1.sig, 8'h00);
      tick();
      chk("t1_sig1", if1.sig, 8'h01);
      chk("t1_busy1", if1.busy, 1'b1);
      tick();
      chk("t1_sig2", if1.sig, 8'h03);
      chk("t1_busy2", if1.busy, 1'b1);
      tick();
      chk("t1_sig3", if1.sig, 8'h07);
      chk("t1_busy3", if1.busy, 1'b0);
      chk("t1_done", if1.done, 1'b1);
      chk("t1_xor1", if1.sig_xor, 8'h07);
      tick();
      chk("t1_hold", if1.sig, 8'h07);
      chk("t1_done_hold", if1.done, 1'b1);

      // 2: feedback, restart from DONE re-zeroes
      start = 1'b1; run_len = 8'd2; din1 = 8'h80;
      tick();
      start = 1'b0;
      chk("t2_zero", if1.sig, 8'h00);
      tick();
      chk("t2_sig1", if1.sig, 8'h80);
      din1 = 8'h00;
      tick();
      chk("t2_sig2", if1.sig, 8'h1D);
      chk("t2_done", if1.done, 1'b1);

      // 3: run_len=0 -> DONE directly
      start = 1'b1; run_len = 8'd0;
      tick();
      start = 1'b0;
      chk("t3_busy", if1.busy, 1'b0);
      chk("t3_done", if1.done, 1'b1);
      chk("t3_sig", if1.sig, 8'h00);
      tick();
      chk("t3_busy_b", if1.busy, 1'b0);

      // 4: clr in RUN, then clr+start together
      start = 1'b1; run_len = 8'd5; din1 = 8'h01;
      tick();
      start = 1'b0;
      tick();
      chk("t4_sig1", if1.sig, 8'h01);
      clr = 1'b1;
      tick();
      chk("t4_sig", if1.sig, 8'h00);
      chk("t4_busy", if1.busy, 1'b0);
      chk("t4_done", if1.done, 1'b0);
      start = 1'b1; run_len = 8'd3;
      tick();
      chk("t4_cs_busy", if1.busy, 1'b0);
      chk("t4_cs_done", if1.done, 1'b0);
      clr = 1'b0; start = 1'b0;

      // 5: four channels, run_len=1, restart from DONE
      din4 = 32'h08040201;
      start = 1'b1; run_len = 8'd1;
      tick();
      start = 1'b0;
      chk("t5_busy", if4.busy, 1'b1);
      tick();
      chk("t5_sig", if4.sig, 32'h08040201);
      chk("t5_xor", if4.sig_xor, 8'h0F);
      chk("t5_done", if4.done, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_rz_sig", if4.sig, 32'h0);
      chk("t5_rz_busy", if4.busy, 1'b1);
      tick();
      chk("t5_sig_b", if4.sig, 32'h08040201);

      // 6: async reset mid-RUN, start held high across release
      start = 1'b1; run_len = 8'd5; din1 = 8'h01;
      tick();
      tick();
      chk("t6_pre", if1.sig, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_sig1", if1.sig, 8'h00);
      chk("t6_sig4", if4.sig, 32'h0);
      chk("t6_xor4", if4.sig_xor, 8'h00);
      chk("t6_busy", if1.busy, 1'b0);
      #1 rst_n = 1'b1;
      #1;
      chk("t6_rel_busy", if1.busy, 1'b0);
      tick();
      start = 1'b0;
      chk("t6_start_busy", if1.busy, 1'b1);
      chk("t6_start_sig", if1.sig, 8'h00);
      tick();
      chk("t6_upd", if1.sig, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
